// File: rtl/regfile_param.sv
`default_nettype none
// ----------------------------------------------------------------------------
// regfile_param : DEPTH x WIDTH register file, two combinational reads, one
//                 synchronous write, optional zero register and write bypass.
// Revision      : 1.0
// ----------------------------------------------------------------------------
module regfile_param #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 32,
  parameter int ADDR_W   = $clog2(DEPTH),
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr1,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [WIDTH-1:0]  rdata1,
  output logic [WIDTH-1:0]  rdata2
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             wr_en;

  // One qualifier drives both the array update and the bypass path, so a
  // suppressed write can never be forwarded.
  always_comb begin
    wr_en = rst_n && we && (int'(waddr) < DEPTH) &&
            !((ZERO_REG != 0) && (waddr == '0));
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
      if (wr_en && (int'(waddr) == i)) begin
        mem_d[i] = wdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  function automatic logic [WIDTH-1:0] rd_sel(
    input logic [ADDR_W-1:0] ra,
    input logic [WIDTH-1:0]  stored,
    input logic              wen,
    input logic [ADDR_W-1:0] wa,
    input logic [WIDTH-1:0]  wd
  );
    logic [WIDTH-1:0] res;
    res = '0;
    if (int'(ra) >= DEPTH) begin
      res = '0;
    end else if ((ZERO_REG != 0) && (ra == '0)) begin
      res = '0;
    end else if ((BYPASS != 0) && wen && (wa == ra)) begin
      res = wd;
    end else begin
      res = stored;
    end
    return res;
  endfunction

  assign rdata1 = rd_sel(raddr1, mem_q[raddr1], wr_en, waddr, wdata);
  assign rdata2 = rd_sel(raddr2, mem_q[raddr2], wr_en, waddr, wdata);

endmodule
`default_nettype wire

// File: tb/tb_regfile_param.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_regfile_param : scoreboarded random and directed bench for regfile_param
// Revision         : 1.0
// ----------------------------------------------------------------------------
module tb_regfile_param;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [4:0]  raddr1;
  logic [4:0]  raddr2;
  logic [31:0] r1a, r2a, r1b, r2b;
  logic [7:0]  r1c, r2c;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // A: 32x32 zero-reg + bypass; B: 32x32 plain storage, no bypass;
  // C: 24x8 plain register 0 with bypass.
  regfile_param #(.WIDTH(32), .DEPTH(32), .ZERO_REG(1), .BYPASS(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr1(raddr1), .raddr2(raddr2), .rdata1(r1a), .rdata2(r2a));

  regfile_param #(.WIDTH(32), .DEPTH(32), .ZERO_REG(0), .BYPASS(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr1(raddr1), .raddr2(raddr2), .rdata1(r1b), .rdata2(r2b));

  regfile_param #(.WIDTH(8), .DEPTH(24), .ZERO_REG(0), .BYPASS(1)) dut_c (
    .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata[7:0]),
    .raddr1(raddr1), .raddr2(raddr2), .rdata1(r1c), .rdata2(r2c));

  // Reference model: one plain array per configuration.
  logic [31:0] mdl [3][32];

  function automatic int  cfg_depth(int d); return (d == 2) ? 24 : 32; endfunction
  function automatic bit  cfg_zero(int d);  return d == 0;             endfunction
  function automatic bit  cfg_byp(int d);   return d != 1;             endfunction
  function automatic logic [31:0] cfg_mask(int d);
    return (d == 2) ? 32'h0000_00FF : 32'hFFFF_FFFF;
  endfunction

  function automatic bit write_takes(int d, logic rn, logic w, logic [4:0] wa);
    return rn && w && (int'(wa) < cfg_depth(d)) && !(cfg_zero(d) && wa == 5'd0);
  endfunction

  function automatic logic [31:0] mdl_read(int d, logic rn, logic w, logic [4:0] wa,
                                           logic [31:0] wd, logic [4:0] ra);
    if (int'(ra) >= cfg_depth(d))               return 32'h0;
    if (cfg_zero(d) && ra == 5'd0)              return 32'h0;
    if (cfg_byp(d) && write_takes(d, rn, w, wa) && wa == ra) return wd & cfg_mask(d);
    return mdl[d][ra];
  endfunction

  typedef struct packed {
    logic [2:0][31:0] e1;
    logic [2:0][31:0] e2;
  } exp_t;

  exp_t sb[$];

  task automatic drive(input logic rn, input logic w, input logic [4:0] wa,
                       input logic [31:0] wd, input logic [4:0] a1, input logic [4:0] a2);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n = rn; we = w; waddr = wa; wdata = wd; raddr1 = a1; raddr2 = a2;
    for (int d = 0; d < 3; d++) begin
      e.e1[d] = mdl_read(d, rn, w, wa, wd, a1);
      e.e2[d] = mdl_read(d, rn, w, wa, wd, a2);
    end
    sb.push_back(e);
    // Model the effect of the coming edge.
    for (int d = 0; d < 3; d++) begin
      if (!rn) begin
        for (int i = 0; i < 32; i++) mdl[d][i] = 32'h0;
      end else if (write_takes(d, rn, w, wa)) begin
        mdl[d][wa] = wd & cfg_mask(d);
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Monitor: outputs are combinational, so every driven cycle presents a result.
  initial begin
    exp_t e;
    logic [31:0] a1 [3];
    logic [31:0] a2 [3];
    forever begin
      @(negedge clk);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        a1[0] = r1a; a1[1] = r1b; a1[2] = {24'h0, r1c};
        a2[0] = r2a; a2[1] = r2b; a2[2] = {24'h0, r2c};
        for (int d = 0; d < 3; d++) begin
          checks++;
          if (a1[d] !== e.e1[d]) begin
            errors++;
            $display("FAIL sb_rdata1_dut%0d actual=%h required=%h", d, a1[d], e.e1[d]);
          end
          checks++;
          if (a2[d] !== e.e2[d]) begin
            errors++;
            $display("FAIL sb_rdata2_dut%0d actual=%h required=%h", d, a2[d], e.e2[d]);
          end
        end
      end
    end
  end

  initial begin
    logic [4:0]  wa, a1, a2;
    logic [31:0] wd;
    logic        rn, w;
    int          waited;

    rst_n = 1'b0; we = 1'b0; waddr = '0; wdata = '0; raddr1 = '0; raddr2 = '0;
    for (int d = 0; d < 3; d++)
      for (int i = 0; i < 32; i++) mdl[d][i] = 32'h0;
    repeat (2) @(posedge clk);

    // Reset overrides a write presented in the same cycle.
    for (int i = 1; i < 32; i++) drive(1, 1, 5'(i), $urandom | 32'h1, 5'(i), 5'(31 - i));
    drive(0, 1, 5'd5, 32'hFFFF_FFFF, 5'd5, 5'd5);
    for (int i = 0; i < 32; i++) begin
      drive(1, 0, 5'd0, 32'h0, 5'(i), 5'(i));
      #1;
      chk("reset_a1", r1a, 32'h0);
      chk("reset_b2", r2b, 32'h0);
    end

    drive(1, 1, 5'd7,  32'hDEAD_BEEF, 5'd0, 5'd0);
    drive(1, 1, 5'd31, 32'h1234_5678, 5'd0, 5'd0);
    drive(1, 0, 5'd0,  32'h0, 5'd7, 5'd31);
    #1;
    chk("wr_a_reg7",  r1a, 32'hDEAD_BEEF);
    chk("wr_a_reg31", r2a, 32'h1234_5678);
    chk("wr_b_reg7",  r1b, 32'hDEAD_BEEF);
    chk("wr_c_reg7",  {24'h0, r1c}, 32'h0000_00EF);
    chk("wr_c_oob31", {24'h0, r2c}, 32'h0);

    drive(1, 1, 5'd0, 32'hA5A5_A5A5, 5'd0, 5'd0);
    #1;
    chk("zero_a_during", r1a, 32'h0);
    chk("zero_b_during", r1b, 32'h0);
    drive(1, 0, 5'd0, 32'h0, 5'd0, 5'd0);
    #1;
    chk("zero_a_after", r1a, 32'h0);
    chk("zero_b_after", r1b, 32'hA5A5_A5A5);
    chk("zero_c_after", {24'h0, r1c}, 32'h0000_00A5);

    drive(1, 1, 5'd9, 32'h1, 5'd0, 5'd0);
    drive(1, 1, 5'd9, 32'h2, 5'd9, 5'd9);
    #1;
    chk("byp_a1", r1a, 32'h2);
    chk("byp_a2", r2a, 32'h2);
    chk("nobyp_b1_before", r1b, 32'h1);
    chk("nobyp_b2_before", r2b, 32'h1);
    chk("byp_c1", {24'h0, r1c}, 32'h2);
    drive(1, 0, 5'd0, 32'h0, 5'd9, 5'd9);
    #1;
    chk("nobyp_b1_after", r1b, 32'h2);

    drive(1, 1, 5'd23, 32'h3C, 5'd0, 5'd0);
    drive(1, 1, 5'd30, 32'h77, 5'd23, 5'd30);
    #1;
    chk("np2_oob_no_bypass", {24'h0, r2c}, 32'h0);
    drive(1, 0, 5'd0, 32'h0, 5'd23, 5'd30);
    #1;
    chk("np2_reg23", {24'h0, r1c}, 32'h3C);
    chk("np2_reg30", {24'h0, r2c}, 32'h0);
    for (int i = 0; i < 32; i++) drive(1, 0, 5'd0, 32'h0, 5'(i), 5'(31 - i));

    for (int c = 0; c < 1000; c++) begin
      rn = !(c == 300 || c == 700);
      w  = ($urandom_range(0, 3) != 0);
      wa = 5'($urandom_range(0, 31));
      wd = $urandom;
      a1 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
      a2 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
      drive(rn, w, wa, wd, a1, a2);
    end
    drive(1, 0, 5'd0, 32'h0, 5'd1, 5'd2);

    waited = 0;
    while (sb.size() != 0 && waited < 10) begin
      @(posedge clk);
      waited++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL sb_drain actual=%0d required=0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
